// File: rtl/mem_loader_pkg.sv
// Shared definitions for the memory loader: default widths, the program base
// address and the loader FSM state encoding.
package mem_loader_pkg;

  localparam int DEF_ADDR_WIDTH   = 16;
  localparam int DEF_REG_WIDTH    = 8;
  localparam int INSTRUCTION_BASE = 'h0200;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_WRITE,
    ST_READ,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/byte_checksum.sv
// Running modulo-2^W sum of accepted bytes with synchronous clear.
module byte_checksum #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         add,
  input  logic [W-1:0] data,
  output logic [W-1:0] sum
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add) begin
      sum <= sum + data;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Loads a byte stream into memory from BASE_ADDR with write/readback verify,
// owning the memory port and holding the core in reset until the load succeeds.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_REG_WIDTH,
  parameter int BASE_ADDR  = INSTRUCTION_BASE,
  parameter int LENGTH     = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  mem_owner,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  core_reset_n,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [DATA_WIDTH-1:0] checksum,
  output state_t                fsm_state
);

  if (LENGTH <= 0 ||
      (longint'(BASE_ADDR) + longint'(LENGTH)) > (longint'(1) << ADDR_WIDTH)) begin : g_param_check
    $error("mem_loader: LENGTH must be > 0 and BASE_ADDR + LENGTH must fit the address space");
  end

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LENGTH - 1);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] count, count_next;
  logic [DATA_WIDTH-1:0] hold, hold_next;
  logic [ADDR_WIDTH-1:0] err_next;
  logic [ADDR_WIDTH-1:0] addr_cur;
  logic                  cs_clear, cs_add;

  // Handshake: a byte moves when s_valid && s_ready at a rising edge; s_ready
  // is high only in ACCEPT, and s_valid/s_data are ignored in every other state.
  assign addr_cur = BASE + count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      count    <= '0;
      hold     <= '0;
      err_addr <= '0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      hold     <= hold_next;
      err_addr <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    hold_next  = hold;
    err_next   = err_addr;
    cs_clear   = 1'b0;
    cs_add     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_next = ST_ACCEPT;
          count_next = '0;
          err_next   = '0;
          cs_clear   = 1'b1;
        end
      end
      ST_ACCEPT: begin
        if (s_valid) begin
          state_next = ST_WRITE;
          hold_next  = s_data;
          cs_add     = 1'b1;
        end
      end
      ST_WRITE: state_next = ST_READ;
      ST_READ:  state_next = ST_CHECK;
      ST_CHECK: begin
        if (mem_dout != hold) begin
          state_next = ST_ERROR;
          err_next   = addr_cur;
        end else if (count == LAST) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_ACCEPT;
          count_next = count + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  byte_checksum #(.W(DATA_WIDTH)) u_checksum (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cs_clear),
    .add     (cs_add),
    .data    (s_data),
    .sum     (checksum)
  );

  // Every output below is a decode of registered state, never of s_valid or mem_dout.
  assign s_ready      = (state == ST_ACCEPT);
  assign mem_we       = (state == ST_WRITE);
  assign mem_addr     = (state inside {ST_WRITE, ST_READ, ST_CHECK}) ? addr_cur : '0;
  assign mem_din      = (state == ST_WRITE) ? hold : '0;
  assign mem_owner    = (state != ST_DONE);
  assign core_reset_n = (state == ST_DONE);
  assign done         = (state == ST_DONE);
  assign error        = (state == ST_ERROR);
  assign fsm_state    = state;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: table-driven byte loads plus hand-written
// sequences for stall, mismatch, retry, mid-load reset and reload.
module tb_mem_loader;
  import mem_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready, mem_owner, mem_we, core_reset_n, done, error;
  logic [15:0] mem_addr, err_addr;
  logic [7:0]  mem_din, mem_dout, checksum;
  state_t      fsm_state;

  mem_loader #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (8),
    .BASE_ADDR  ('h0040),
    .LENGTH     (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .mem_owner    (mem_owner),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout),
    .core_reset_n (core_reset_n),
    .done         (done),
    .error        (error),
    .err_addr     (err_addr),
    .checksum     (checksum),
    .fsm_state    (fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- memory model (mux selected by mem_owner) ----------------
  logic [7:0] mem [0:65535];
  logic       corrupt_en = 1'b0;
  int         cyc = 0;
  int         write_count = 0;
  int         start_cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_owner && mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= (corrupt_en && mem_addr == 16'h0042) ? 8'h00 : mem[mem_addr];
  end

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [23:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_owner && mem_we) begin
      write_count++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected write: actual %0h:%0h required none", mem_addr, mem_din);
      end else begin
        check("write addr/data", {8'h00, mem_addr, mem_din}, {8'h00, exp_q.pop_front()});
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0]  data;
    logic [15:0] addr;
    logic [7:0]  csum;
  } vec_t;

  vec_t nom[4];
  vec_t alt[4];

  // ---------------- driver tasks ----------------
  task automatic check_reset(input string tag);
    check({tag, " s_ready"},      s_ready, 0);
    check({tag, " mem_we"},       mem_we, 0);
    check({tag, " mem_addr"},     mem_addr, 0);
    check({tag, " mem_din"},      mem_din, 0);
    check({tag, " mem_owner"},    mem_owner, 1);
    check({tag, " core_reset_n"}, core_reset_n, 0);
    check({tag, " done"},         done, 0);
    check({tag, " error"},        error, 0);
    check({tag, " err_addr"},     err_addr, 0);
    check({tag, " checksum"},     checksum, 0);
    check({tag, " state"},        32'(fsm_state), 32'(ST_IDLE));
  endtask

  task automatic do_start();
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    check("start s_ready", s_ready, 1);
    check("start mem_owner", mem_owner, 1);
    check("start core_reset_n", core_reset_n, 0);
    check("start done", done, 0);
    check("start error", error, 0);
    check("start err_addr", err_addr, 0);
    check("start checksum", checksum, 0);
  endtask

  task automatic send_vec(input vec_t v, input int gap);
    int n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("s_ready wait", s_ready, 1);
    for (int g = 0; g < gap; g++) begin
      s_valid = 1'b0;
      @(negedge clk);
      check("stall s_ready", s_ready, 1);
      check("stall mem_we", mem_we, 0);
    end
    s_valid = 1'b1;
    s_data  = v.data;
    exp_q.push_back({v.addr, v.data});
    @(negedge clk);
    check("checksum", checksum, v.csum);
  endtask

  task automatic load_table(input bit use_alt, input int gap);
    for (int i = 0; i < 4; i++) send_vec(use_alt ? alt[i] : nom[i], gap);
    s_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done seen", done, 1);
    check("done core_reset_n", core_reset_n, 1);
    check("done mem_owner", mem_owner, 0);
    check("done error", error, 0);
  endtask

  task automatic check_mem(input bit use_alt);
    for (int i = 0; i < 4; i++) begin
      vec_t v;
      v = use_alt ? alt[i] : nom[i];
      check("mem contents", mem[v.addr], v.data);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int wc0;
    int n;
    nom[0] = '{8'hA9, 16'h0040, 8'hA9};
    nom[1] = '{8'h05, 16'h0041, 8'hAE};
    nom[2] = '{8'h8D, 16'h0042, 8'h3B};
    nom[3] = '{8'h10, 16'h0043, 8'h4B};
    alt[0] = '{8'h01, 16'h0040, 8'h01};
    alt[1] = '{8'hFF, 16'h0041, 8'h00};
    alt[2] = '{8'h20, 16'h0042, 8'h20};
    alt[3] = '{8'h33, 16'h0043, 8'h53};

    repeat (2) @(negedge clk);
    check_reset("in reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_reset("idle");

    // Nominal load with s_valid held high.
    wc0 = write_count;
    do_start();
    load_table(1'b0, 0);
    wait_done();
    check("done latency", cyc - start_cyc, 17);
    check("nominal checksum", checksum, 8'h4B);
    check("nominal writes", write_count - wc0, 4);
    check_mem(1'b0);

    // Reload from DONE with different data.
    wc0 = write_count;
    do_start();
    load_table(1'b1, 0);
    wait_done();
    check("reload checksum", checksum, 8'h53);
    check("reload writes", write_count - wc0, 4);
    check_mem(1'b1);

    // Host stall: three idle cycles before each byte.
    wc0 = write_count;
    do_start();
    load_table(1'b0, 3);
    wait_done();
    check("stall checksum", checksum, 8'h4B);
    check("stall writes", write_count - wc0, 4);
    check_mem(1'b0);

    // Forced mismatch on the third readback.
    corrupt_en = 1'b1;
    do_start();
    for (int i = 0; i < 3; i++) send_vec(nom[i], 0);
    s_valid = 1'b0;
    n = 0;
    while (!error && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mismatch error", error, 1);
    check("mismatch err_addr", err_addr, 16'h0042);
    check("mismatch core_reset_n", core_reset_n, 0);
    check("mismatch done", done, 0);
    check("mismatch mem_owner", mem_owner, 1);
    check("mismatch state", 32'(fsm_state), 32'(ST_ERROR));
    check("mismatch pending writes", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("error holds", error, 1);

    // Retry from ERROR.
    corrupt_en = 1'b0;
    do_start();
    load_table(1'b0, 0);
    wait_done();
    check("retry checksum", checksum, 8'h4B);
    check_mem(1'b0);

    // Async reset during WRITE of the second byte.
    do_start();
    send_vec('{8'h77, 16'h0040, 8'h77}, 0);
    send_vec('{8'h66, 16'h0041, 8'hDD}, 0);
    s_valid = 1'b0;
    check("midload in write", mem_we, 1);
    check("midload addr", mem_addr, 16'h0041);
    #1 reset_n = 1'b0;
    #1 check_reset("async reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset("after reset");
    check("partial byte0", mem[16'h0040], 8'h77);
    check("partial byte1 untouched", mem[16'h0041], 8'h05);
    check("midload pending writes", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
# mem_loader

Program/data loader: the writing side of the memory that the fetcher reads. On `start` it takes ownership of the memory port and holds the core in reset. It accepts a byte stream over a valid/ready handshake and writes each byte to consecutive addresses from `BASE_ADDR`, reading every byte back to verify it. After the last byte verifies, it releases memory and core reset. This replaces bench-side manual memory loading and sits between the external host/bench and the `mem` write mux.

## Interface
- `ADDR_WIDTH`, 16, memory address width.
- `DATA_WIDTH`, 8, byte width (matches register width).
- `BASE_ADDR`, `INSTRUCTION_BASE`, first address written.
- `LENGTH`, 256, number of bytes per load; elaboration error if 0 or if `BASE_ADDR + LENGTH > 2**ADDR_WIDTH`.

- `clk`  in  1  single clock, rising edge; connects to phi2 as `mem` does.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled request to begin a load.
- `s_valid`  in  1  host byte valid.
- `s_data`  in  DATA_WIDTH  host byte.
- `s_ready`  out  1  loader can accept a byte.
- `mem_owner`  out  1  selects loader onto the mem addr/din/we mux.
- `mem_we`  out  1  mem write enable.
- `mem_addr`  out  ADDR_WIDTH  mem address.
- `mem_din`  out  DATA_WIDTH  mem write data.
- `mem_dout`  in  DATA_WIDTH  mem read data, valid one cycle after the address.
- `core_reset_n`  out  1  reset to the fetcher, decoder, ALU and registers.
- `done`  out  1  load complete and verified.
- `error`  out  1  verify mismatch.
- `err_addr`  out  ADDR_WIDTH  address of the first mismatch.
- `checksum`  out  DATA_WIDTH  mod-2^DATA_WIDTH sum of the bytes accepted.

## Operation
- States: IDLE, ACCEPT, WRITE, READ, CHECK, DONE, ERROR.
- IDLE: `mem_owner`=1, `core_reset_n`=0. When `start`=1, clear the count and `checksum` and go to ACCEPT.
- ACCEPT: `s_ready`=1.
  - On `s_valid && s_ready`: latch `s_data` into the hold register and add it to `checksum`.
  - Go to WRITE.
- WRITE:
  - `mem_we`=1, `mem_addr`=`BASE_ADDR`+count, `mem_din`=hold.
  - Go to READ.
- READ: `mem_we`=0, same address. Go to CHECK.
- CHECK: compare `mem_dout` with hold.
  - Mismatch: latch `err_addr`=`mem_addr` and go to ERROR.
  - Match, count=`LENGTH`-1: go to DONE.
  - Match otherwise: increment count and go to ACCEPT.
- DONE: `done`=1, `mem_owner`=0, `core_reset_n`=1. `start`=1 begins a new load (back to ACCEPT with count and checksum cleared), re-asserting core reset and `mem_owner` in the same transition.
- ERROR: `error`=1, `core_reset_n`=0, `mem_owner`=1. `start`=1 retries the whole load from count 0 and clears `error`/`err_addr`.
- `start` is ignored in ACCEPT, WRITE, READ and CHECK.
- `s_valid` is ignored outside ACCEPT. The host may hold `s_data` stable for any number of cycles.
- Address arithmetic is ADDR_WIDTH-bit. The count never exceeds `LENGTH`-1, so the address never wraps.

## Timing
- Reset values:
  - state IDLE, `s_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0.
  - `mem_owner`=1, `core_reset_n`=0, `done`=0, `error`=0, `err_addr`=0, `checksum`=0.
- All outputs are registered or decoded from state only. No combinational path from `s_valid` or `mem_dout` to any output.
- Per byte, minimum 4 cycles: ACCEPT(handshake) → WRITE → READ → CHECK.
- Full load minimum is 4·`LENGTH` cycles plus 1 cycle from `start` to ACCEPT.
- `start` high in IDLE at edge N gives `s_ready`=1 after edge N.
- Last CHECK match at edge M gives `done`=1, `core_reset_n`=1 and `mem_owner`=0 after edge M, all together.
- Async reset mid-load: return to reset values immediately. The partially written memory is left as is, and the core stays in reset.

## Structure
- Shared package: the state enum, the `ADDR_WIDTH`/`REG_WIDTH` defines and the `INSTRUCTION_BASE` define all stay in `PKG/pkg.v`.
- One sub-module is natural: `byte_checksum` (clear, add-enable, accumulator).
- `mem_loader` instantiates `mem`'s write-side mux select via `mem_owner`; the mux itself stays at top level.

## Test plan
All scenarios use `BASE_ADDR`=16'h0040 and `LENGTH`=4.
- Nominal load:
  - Stimulus: reset, `start`, send A9,05,8D,10 with `s_valid` held high.
  - Required: mem[0040..0043]=A9,05,8D,10; `checksum`=0x4B; `done`=1 exactly 17 cycles after `start`; `core_reset_n` rises with `done`.
- Host stall: insert 3 idle cycles between bytes → identical memory contents; `s_ready` stays high during the gaps and no extra writes occur.
- Forced mismatch: the bench corrupts `mem_dout` to 00 on the 3rd readback → `error`=1, `err_addr`=0042, `core_reset_n`=0, `done`=0.
- Retry from ERROR: pulse `start` and resend the 4 bytes → `error` clears, then `done`=1.
- Reset mid-load: deassert `reset_n` during WRITE of the 2nd byte → all outputs take reset values asynchronously, before the next edge.
- Reload from DONE: `start` in DONE → `core_reset_n`=0 and `mem_owner`=1 on the next edge; the new load overwrites 0040..0043.
